// File: rtl/g7_fetch_issue_ctrl.sv
// g7 fetch/issue/commit sequencer: one instruction in flight, owns the 32x32 regfile and PC.
// Optional performance counters (instret, stall_cnt) are built when G7_PERF_CNT_EN is defined.
module g7_fetch_issue_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  output logic [6:0]  opcode,
  output logic [3:0]  func,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  input  logic [31:0] sonuc,
  input  logic        pc_update,
  input  logic        we,
  input  logic        hata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
`ifdef G7_PERF_CNT_EN
  output logic [31:0] instret,
  output logic [31:0] stall_cnt,
`endif
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  // state   | meaning
  // S_IDLE  | waiting for en
  // S_FETCH | imem request outstanding, timeout counter running
  // S_EXEC  | operands presented, commit at end of cycle
  // S_TRAP  | halted until reset
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_TRAP} state_t;

  localparam logic [6:0]  OP_R   = 7'h01;
  localparam logic [6:0]  OP_I   = 7'h03;
  localparam logic [6:0]  OP_U   = 7'h07;
  localparam logic [6:0]  OP_B   = 7'h0F;
  localparam logic [15:0] TO_LIM = 16'(IMEM_TIMEOUT);

  state_t      state, state_nx;
  logic [31:0] instr;
  logic [15:0] tcnt, tcnt_inc;
  logic [31:0] regfile [32];
  logic [4:0]  rd, rs1, rs2;
  logic        func_ok, illegal, timeout_hit;
  logic [31:0] br_off, pc_nx;

  assign rd  = instr[11:7];
  assign rs1 = instr[20:16];
  assign rs2 = instr[25:21];

  // Decoded fields track the latched instruction, so they hold outside EXEC for free.
  assign opcode = instr[6:0];
  assign func   = instr[15:12];

  always_comb begin
    imm = 32'h0;
    case (instr[6:0])
      OP_I:    imm = {{21{instr[31]}}, instr[31:21]};
      OP_U:    imm = {12'h000, instr[31:12]};
      OP_B:    imm = {{21{instr[31]}}, instr[31:26], instr[11:7]};
      default: imm = 32'h0;
    endcase
  end

  assign rs1_data  = regfile[rs1];
  assign rs2_data  = regfile[rs2];
  assign dbg_rdata = regfile[dbg_raddr];
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  // Local legality check: an X or bogus result from the execute unit cannot mask a bad opcode/func.
  always_comb begin
    func_ok = 1'b0;
    case (instr[6:0])
      OP_R: case (instr[15:12])
              4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hD: func_ok = 1'b1;
              default: func_ok = 1'b0;
            endcase
      OP_I: case (instr[15:12])
              4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7: func_ok = 1'b1;
              default: func_ok = 1'b0;
            endcase
      OP_B: case (instr[15:12])
              4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: func_ok = 1'b1;
              default: func_ok = 1'b0;
            endcase
      OP_U:    func_ok = 1'b1;
      default: func_ok = 1'b0;
    endcase
  end

  assign illegal     = hata | ~func_ok;
  assign tcnt_inc    = tcnt + 16'd1;
  assign timeout_hit = (tcnt_inc == TO_LIM);
  assign br_off      = sonuc << 2;
  assign pc_nx       = pc_update ? (pc + br_off) : (pc + 32'd4);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (en) state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_gnt)         state_nx = S_EXEC;
        else if (timeout_hit) state_nx = S_TRAP;
      end
      S_EXEC: begin
        if (illegal) state_nx = S_TRAP;
        else         state_nx = en ? S_FETCH : S_IDLE;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      instr      <= 32'h0;
      tcnt       <= 16'h0;
      retire     <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      for (int i = 0; i < 32; i++) regfile[i] <= 32'h0;
    end else begin
      state  <= state_nx;
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_gnt) begin
            instr <= imem_rdata;
            tcnt  <= 16'h0;
          end else begin
            tcnt <= tcnt_inc;
            if (timeout_hit) begin
              trap       <= 1'b1;
              trap_cause <= 2'b10;
            end
          end
        end
        S_EXEC: begin
          if (illegal) begin
            trap       <= 1'b1;
            trap_cause <= 2'b01;
          end else begin
            if (we && rd != 5'd0) regfile[rd] <= sonuc;
            pc     <= pc_nx;
            retire <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef G7_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret   <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (retire) instret <= instret + 32'd1;
      if (state == S_FETCH && !imem_gnt) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_g7_fetch_issue_ctrl.sv
// Directed bench for g7_fetch_issue_ctrl: the bench plays imem and the execute unit.
module tb_g7_fetch_issue_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n, en, imem_gnt, pc_update, we, hata;
  logic [31:0] imem_rdata, sonuc;
  logic [4:0]  dbg_raddr;
  logic        imem_req, retire, trap;
  logic [31:0] imem_addr, rs1_data, rs2_data, imm, pc, dbg_rdata;
  logic [6:0]  opcode;
  logic [3:0]  func;
  logic [1:0]  trap_cause;

  int n_tests = 0;
  int n_fail  = 0;

  g7_fetch_issue_ctrl #(.RESET_PC(32'h0), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rdata(imem_rdata),
    .opcode(opcode), .func(func), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .sonuc(sonuc), .pc_update(pc_update), .we(we), .hata(hata),
    .pc(pc), .retire(retire), .trap(trap), .trap_cause(trap_cause),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_gnt = 1'b1;
    imem_rdata = w;
    step();
    imem_gnt = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic exec(input logic [31:0] s, input logic pu, input logic w, input logic h);
    sonuc = s; pc_update = pu; we = w; hata = h;
    step();
    sonuc = 32'h0; pc_update = 1'b0; we = 1'b0; hata = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic start();
    en = 1'b1;
    step();
  endtask

  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] v);
    return {v, rd, 7'h07};
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; imem_gnt = 1'b0; imem_rdata = 32'h0;
    sonuc = 32'h0; pc_update = 1'b0; we = 1'b0; hata = 1'b0; dbg_raddr = 5'd0;
    @(negedge clk);
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_trap", {30'h0, trap_cause} | 32'(trap), 32'h0);
    chk("rst_opc", {21'h0, func, opcode}, 32'h0);
    chk("rst_imm", imm, 32'h0);
    step();
    chk("idle_hold", 32'(imem_req), 32'h0);

    // 1: U-type writeback
    start();
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    fetch(enc_u(5'd3, 20'h00ABC));
    chk("t1_opc", 32'(opcode), 32'h07);
    chk("t1_imm", imm, 32'h0000_0ABC);
    exec(32'hABC, 1'b0, 1'b1, 1'b0);
    chk("t1_retire", 32'(retire), 32'h1);
    chk("t1_pc", pc, 32'h4);
    chk_reg("t1_x3", 5'd3, 32'hABC);
    step();
    chk("t1_retire_pulse", 32'(retire), 32'h0);

    // 2: R-type operand read
    fetch(enc_u(5'd1, 20'h0));
    exec(32'd7, 1'b0, 1'b1, 1'b0);
    fetch(enc_u(5'd2, 20'h0));
    exec(32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0);
    fetch({6'h0, 5'd2, 5'd1, 4'h0, 5'd5, 7'h01});
    chk("t2_rs1", rs1_data, 32'd7);
    chk("t2_rs2", rs2_data, 32'hFFFF_FFFD);
    chk("t2_imm", imm, 32'h0);
    exec(32'd4, 1'b0, 1'b1, 1'b0);
    chk_reg("t2_x5", 5'd5, 32'd4);
    chk("t2_pc", pc, 32'h10);

    // advance to 0x20, the first one also tries to write x0
    fetch(enc_u(5'd0, 20'h0));
    exec(32'hDEAD, 1'b0, 1'b1, 1'b0);
    chk_reg("x0_zero", 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      fetch(enc_u(5'd0, 20'h0));
      exec(32'h0, 1'b0, 1'b0, 1'b0);
    end
    chk("t3_pc_start", pc, 32'h20);

    // 3: branch taken/not taken, imm = -2
    fetch({6'h3F, 5'd0, 5'd0, 4'h0, 5'h1E, 7'h0F});
    chk("t3_imm", imm, 32'hFFFF_FFFE);
    exec(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    chk("t3_taken_pc", pc, 32'h18);
    for (int i = 0; i < 2; i++) begin
      fetch(enc_u(5'd0, 20'h0));
      exec(32'h0, 1'b0, 1'b0, 1'b0);
    end
    fetch({6'h3F, 5'd0, 5'd0, 4'h0, 5'h1E, 7'h0F});
    exec(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    chk("t3_nt_pc", pc, 32'h24);
    chk_reg("t3_x5_kept", 5'd5, 32'd4);

    // 4: illegal opcode
    fetch({25'h0, 7'h05});
    exec(32'h1234, 1'b1, 1'b1, 1'b0);
    chk("t4_trap", 32'(trap), 32'h1);
    chk("t4_cause", 32'(trap_cause), 32'h1);
    chk("t4_pc", pc, 32'h24);
    chk("t4_retire", 32'(retire), 32'h0);
    step(); step(); step();
    chk("t4_req", 32'(imem_req), 32'h0);
    chk("t4_pc_hold", pc, 32'h24);

    // 4b: illegal R func with X from the execute unit
    do_reset();
    start();
    fetch({6'h0, 5'd0, 5'd0, 4'h2, 5'd6, 7'h01});
    exec('x, 1'bx, 1'bx, 1'bx);
    chk("t4b_trap", 32'(trap), 32'h1);
    chk("t4b_cause", 32'(trap_cause), 32'h1);
    chk("t4b_pc", pc, 32'h0);
    chk_reg("t4b_x6", 5'd6, 32'h0);

    // 4c: legal U but hata raised
    do_reset();
    start();
    fetch(enc_u(5'd8, 20'h1));
    exec(32'h77, 1'b0, 1'b1, 1'b1);
    chk("t4c_cause", 32'(trap_cause), 32'h1);
    chk_reg("t4c_x8", 5'd8, 32'h0);

    // 5: fetch timeout
    do_reset();
    start();
    for (int i = 0; i < TO - 1; i++) step();
    chk("t5_not_yet", 32'(trap), 32'h0);
    chk("t5_req", 32'(imem_req), 32'h1);
    step();
    chk("t5_trap", 32'(trap), 32'h1);
    chk("t5_cause", 32'(trap_cause), 32'h2);
    do_reset();
    start();
    for (int i = 0; i < TO - 1; i++) step();
    fetch(enc_u(5'd7, 20'h0));
    chk("t5_late_gnt", 32'(trap), 32'h0);
    exec(32'h55, 1'b0, 1'b1, 1'b0);
    chk_reg("t5_x7", 5'd7, 32'h55);
    chk("t5_pc", pc, 32'h4);

    // 6: reset during EXEC
    do_reset();
    start();
    fetch(enc_u(5'd9, 20'h0));
    exec(32'h99, 1'b0, 1'b1, 1'b0);
    fetch(enc_u(5'd4, 20'h3));
    sonuc = 32'h44; we = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1; sonuc = 32'h0; we = 1'b0;
    chk("t6_pc", pc, 32'h0);
    chk_reg("t6_x4", 5'd4, 32'h0);
    chk_reg("t6_x9", 5'd9, 32'h0);
    chk("t6_imm", imm, 32'h0);
    chk("t6_req", 32'(imem_req), 32'h0);
    step();
    chk("t6_refetch", 32'(imem_req), 32'h1);
    fetch(enc_u(5'd0, 20'h0));
    exec(32'hBEEF, 1'b0, 1'b1, 1'b0);
    chk_reg("t6_x0", 5'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
